// File: rtl/msrv32_pkg.sv
// Shared definitions for the msrv32 store buffer.
//   - AHB-Lite HTRANS / HSIZE encodings used by the drain engine
//   - store-buffer FSM state encoding
//   - buffered entry layout {word address, byte mask, data} and its width
//   - sb_size_lo(): maps a byte mask to {hsize, haddr[1:0]}
package msrv32_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    SB_IDLE = 2'b00,
    SB_ADDR = 2'b01,
    SB_DATA = 2'b10
  } sb_state_e;

  typedef struct packed {
    logic [29:0] waddr;
    logic [3:0]  mask;
    logic [31:0] data;
  } sb_entry_t;

  localparam int SB_ENTRY_W = $bits(sb_entry_t);

  // Returns {hsize, haddr[1:0]}. Masks that are neither a single lane,
  // an aligned halfword nor a full word are issued as a word transfer.
  function automatic logic [4:0] sb_size_lo(input logic [3:0] mask);
    logic [4:0] res;
    case (mask)
      4'b1111: res = {HSIZE_WORD, 2'b00};
      4'b0011: res = {HSIZE_HALF, 2'b00};
      4'b1100: res = {HSIZE_HALF, 2'b10};
      4'b0001: res = {HSIZE_BYTE, 2'b00};
      4'b0010: res = {HSIZE_BYTE, 2'b01};
      4'b0100: res = {HSIZE_BYTE, 2'b10};
      4'b1000: res = {HSIZE_BYTE, 2'b11};
      default: res = {HSIZE_WORD, 2'b00};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/msrv32_sb_fifo.sv
// Store-buffer entry FIFO.
//   clk, rst_n      : clock, synchronous active-low reset (clears pointers/count)
//   push/push_entry : write one entry at the tail
//   pop             : drop the head entry
//   head_entry      : oldest entry (combinational read)
//   next_entry      : entry behind the head, valid when count > 1
//   count           : number of valid entries (0..DEPTH)
//   ld_waddr        : word address to search for load forwarding
//   fwd_hit/mask/data : youngest valid entry whose word address matches
module msrv32_sb_fifo
  import msrv32_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  sb_entry_t        push_entry,
  input  logic             pop,
  output sb_entry_t        head_entry,
  output sb_entry_t        next_entry,
  output logic [CNT_W-1:0] count,
  input  logic [29:0]      ld_waddr,
  output logic             fwd_hit,
  output logic [3:0]       fwd_mask,
  output logic [31:0]      fwd_data
);

  logic [SB_ENTRY_W-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [CNT_W-1:0]      count_reg;

  // Storage needs no reset: validity is carried by count_reg alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[wr_ptr_reg] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign count      = count_reg;
  assign head_entry = sb_entry_t'(mem_reg[rd_ptr_reg]);
  assign next_entry = sb_entry_t'(mem_reg[rd_ptr_reg + PTR_W'(1)]);

  // Slot gi is the entry gi places behind the head, so a higher gi is younger.
  // The in-flight transfer stays at the head until its data phase completes,
  // so it is searched too, including in the cycle it is popped.
  logic [DEPTH-1:0] slot_match;
  logic [PTR_W-1:0] slot_idx   [DEPTH];
  sb_entry_t        slot_entry [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_search
      assign slot_idx[gi]   = rd_ptr_reg + PTR_W'(gi);
      assign slot_entry[gi] = sb_entry_t'(mem_reg[slot_idx[gi]]);
      assign slot_match[gi] = (CNT_W'(gi) < count_reg) &&
                              (slot_entry[gi].waddr == ld_waddr);
    end
  endgenerate

  // Later (younger) matches overwrite earlier ones.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_mask = '0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_match[i]) begin
        fwd_hit  = 1'b1;
        fwd_mask = slot_entry[i].mask;
        fwd_data = slot_entry[i].data;
      end
    end
  end

endmodule

// File: rtl/msrv32_store_buffer.sv
// Posted-write store buffer between the store unit and the AHB-Lite data bus.
// Buffers up to DEPTH stores and drains each as a single NONSEQ write,
// absorbing HREADY wait states. Bus errors set a sticky flag and the address
// of the first failing transfer is kept.
// Optional build macro MSRV32_STORE_FWD_EN enables load forwarding; without
// it the ld_fwd_* outputs are tied to zero.
// Ports:
//   ms_riscv32_mp_clk_in / ms_riscv32_mp_rst_in : clock, sync active-low reset
//   st_dm*_in, st_ready_out   : store-unit enqueue interface (ready = !full)
//   ahb_*                     : AHB-Lite master write signals
//   sb_empty_out              : nothing buffered and bus idle
//   sb_err_out, sb_err_addr_out : sticky bus error and first error address
//   ld_addr_in, ld_fwd_*      : load forwarding lookup
module msrv32_store_buffer
  import msrv32_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic [31:0] st_dmdata_in,
  input  logic [31:0] st_dmaddr_in,
  input  logic [3:0]  st_dmwr_mask_in,
  input  logic        st_dmwr_req_in,
  output logic        st_ready_out,
  output logic [31:0] ahb_haddr_out,
  output logic [1:0]  ahb_htrans_out,
  output logic        ahb_hwrite_out,
  output logic [2:0]  ahb_hsize_out,
  output logic [31:0] ahb_hwdata_out,
  input  logic        ahb_hready_in,
  input  logic        ahb_hresp_in,
  output logic        sb_empty_out,
  output logic        sb_err_out,
  output logic [31:0] sb_err_addr_out,
  input  logic [31:0] ld_addr_in,
  output logic        ld_fwd_hit_out,
  output logic [31:0] ld_fwd_data_out,
  output logic [3:0]  ld_fwd_mask_out
);

  localparam int CNT_W = PTR_W + 1;

  logic             clk;
  logic             rst_n;
  logic [CNT_W-1:0] fifo_count;
  sb_entry_t        head_entry;
  sb_entry_t        next_entry;
  sb_entry_t        push_entry;
  logic             push;
  logic             pop;
  logic             full;
  logic             fwd_hit;
  logic [3:0]       fwd_mask;
  logic [31:0]      fwd_data;

  assign clk   = ms_riscv32_mp_clk_in;
  assign rst_n = ms_riscv32_mp_rst_in;

  // Ready comes from the registered count only, so a pop in a full cycle
  // does not let a store in during that same cycle.
  assign full         = (fifo_count == CNT_W'(DEPTH));
  assign st_ready_out = !full;
  // An all-zero mask is handshaken but writes nothing, so it is dropped here.
  assign push         = st_dmwr_req_in && !full && (st_dmwr_mask_in != 4'b0000);
  assign push_entry   = '{waddr: st_dmaddr_in[31:2],
                          mask:  st_dmwr_mask_in,
                          data:  st_dmdata_in};

  msrv32_sb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head_entry (head_entry),
    .next_entry (next_entry),
    .count      (fifo_count),
    .ld_waddr   (ld_addr_in[31:2]),
    .fwd_hit    (fwd_hit),
    .fwd_mask   (fwd_mask),
    .fwd_data   (fwd_data)
  );

  sb_state_e   state_reg,    state_next;
  logic [1:0]  htrans_reg,   htrans_next;
  logic [31:0] haddr_reg,    haddr_next;
  logic [2:0]  hsize_reg,    hsize_next;
  logic        hwrite_reg,   hwrite_next;
  logic [31:0] hwdata_reg,   hwdata_next;
  logic        err_reg,      err_next;
  logic [31:0] err_addr_reg, err_addr_next;

  logic        issue;
  sb_entry_t   issue_entry;
  logic [1:0]  issue_lo;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= SB_IDLE;
      htrans_reg   <= HTRANS_IDLE;
      haddr_reg    <= '0;
      hsize_reg    <= '0;
      hwrite_reg   <= 1'b0;
      hwdata_reg   <= '0;
      err_reg      <= 1'b0;
      err_addr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      htrans_reg   <= htrans_next;
      haddr_reg    <= haddr_next;
      hsize_reg    <= hsize_next;
      hwrite_reg   <= hwrite_next;
      hwdata_reg   <= hwdata_next;
      err_reg      <= err_next;
      err_addr_reg <= err_addr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    htrans_next   = htrans_reg;
    haddr_next    = haddr_reg;
    hsize_next    = hsize_reg;
    hwrite_next   = hwrite_reg;
    hwdata_next   = hwdata_reg;
    err_next      = err_reg;
    err_addr_next = err_addr_reg;
    pop           = 1'b0;
    issue         = 1'b0;
    issue_entry   = head_entry;
    issue_lo      = 2'b00;

    case (state_reg)
      SB_IDLE: begin
        issue = (fifo_count != '0);
      end
      SB_ADDR: begin
        if (ahb_hready_in) begin
          hwdata_next = head_entry.data;
          htrans_next = HTRANS_IDLE;
          state_next  = SB_DATA;
        end
      end
      SB_DATA: begin
        if (ahb_hready_in) begin
          pop = 1'b1;
          if (ahb_hresp_in) begin
            err_next = 1'b1;
            if (!err_reg) err_addr_next = haddr_reg;
          end
          // Chain straight into the next address phase. When the head was
          // the last entry, a store arriving this cycle is issued directly
          // from the input since it is not yet readable from storage.
          if (fifo_count > CNT_W'(1)) begin
            issue       = 1'b1;
            issue_entry = next_entry;
          end else if (push) begin
            issue       = 1'b1;
            issue_entry = push_entry;
          end else begin
            htrans_next = HTRANS_IDLE;
            hwrite_next = 1'b0;
            state_next  = SB_IDLE;
          end
        end
      end
      default: begin
        htrans_next = HTRANS_IDLE;
        state_next  = SB_IDLE;
      end
    endcase

    if (issue) begin
      {hsize_next, issue_lo} = sb_size_lo(issue_entry.mask);
      haddr_next  = {issue_entry.waddr, issue_lo};
      htrans_next = HTRANS_NONSEQ;
      hwrite_next = 1'b1;
      state_next  = SB_ADDR;
    end
  end

  assign ahb_haddr_out   = haddr_reg;
  assign ahb_htrans_out  = htrans_reg;
  assign ahb_hwrite_out  = hwrite_reg;
  assign ahb_hsize_out   = hsize_reg;
  assign ahb_hwdata_out  = hwdata_reg;
  assign sb_empty_out    = (fifo_count == '0) && (state_reg == SB_IDLE);
  assign sb_err_out      = err_reg;
  assign sb_err_addr_out = err_addr_reg;

  // Byte offsets are implied by the mask, so the low address bits are unused.
  logic addr_lo_unused;
  assign addr_lo_unused = ^{st_dmaddr_in[1:0], ld_addr_in[1:0]};

`ifdef MSRV32_STORE_FWD_EN
  assign ld_fwd_hit_out  = fwd_hit;
  assign ld_fwd_mask_out = fwd_mask;
  assign ld_fwd_data_out = fwd_data;
`else
  logic fwd_unused;
  assign fwd_unused      = ^{fwd_hit, fwd_mask, fwd_data};
  assign ld_fwd_hit_out  = 1'b0;
  assign ld_fwd_mask_out = '0;
  assign ld_fwd_data_out = '0;
`endif

endmodule

// File: tb/tb_msrv32_store_buffer.sv
// Self-checking bench for msrv32_store_buffer: directed scenarios with literal
// expectations plus randomized traffic against a queue-based reference model.
module tb_msrv32_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] st_data;
  logic [31:0] st_addr;
  logic [3:0]  st_mask;
  logic        st_req;
  logic        st_ready;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready;
  logic        hresp;
  logic        sb_empty;
  logic        sb_err;
  logic [31:0] sb_err_addr;
  logic [31:0] ld_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic [3:0]  fwd_mask;

  always #5 clk = ~clk;

  msrv32_store_buffer #(.DEPTH(DEPTH)) dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst_n),
    .st_dmdata_in         (st_data),
    .st_dmaddr_in         (st_addr),
    .st_dmwr_mask_in      (st_mask),
    .st_dmwr_req_in       (st_req),
    .st_ready_out         (st_ready),
    .ahb_haddr_out        (haddr),
    .ahb_htrans_out       (htrans),
    .ahb_hwrite_out       (hwrite),
    .ahb_hsize_out        (hsize),
    .ahb_hwdata_out       (hwdata),
    .ahb_hready_in        (hready),
    .ahb_hresp_in         (hresp),
    .sb_empty_out         (sb_empty),
    .sb_err_out           (sb_err),
    .sb_err_addr_out      (sb_err_addr),
    .ld_addr_in           (ld_addr),
    .ld_fwd_hit_out       (fwd_hit),
    .ld_fwd_data_out      (fwd_data),
    .ld_fwd_mask_out      (fwd_mask)
  );

  // Reference model: pending stores in order (head = on the bus), and which
  // bus phase the head is in: 0 none, 1 address phase, 2 data phase.
  typedef struct {
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  int          phase = 0;
  logic        m_err = 1'b0;
  logic [31:0] m_err_addr = '0;
  bit          model_valid = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic logic [2:0] exp_hsize(input logic [3:0] m);
    if ($countones(m) == 1) return 3'b000;
    if (m == 4'b0011 || m == 4'b1100) return 3'b001;
    return 3'b010;
  endfunction

  function automatic logic [31:0] exp_haddr(input ent_t e);
    logic [1:0] lo;
    lo = 2'b00;
    if ($countones(e.mask) == 1) begin
      for (int b = 0; b < 4; b++) if (e.mask[b]) lo = 2'(b);
    end else if (e.mask == 4'b1100) begin
      lo = 2'b10;
    end
    return {e.addr[31:2], lo};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic        e_hit;
    logic [3:0]  e_mask;
    logic [31:0] e_data;
    e_hit = 1'b0; e_mask = '0; e_data = '0;
`ifdef MSRV32_STORE_FWD_EN
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].addr[31:2] == ld_addr[31:2]) begin
        e_hit = 1'b1; e_mask = q[i].mask; e_data = q[i].data;
      end
    end
`endif
    chk("ready", 32'(st_ready), 32'(q.size() < DEPTH));
    chk("empty", 32'(sb_empty), 32'(q.size() == 0 && phase == 0));
    chk("htrans", 32'(htrans), (phase == 1) ? 32'h2 : 32'h0);
    if (phase == 1) begin
      chk("haddr", haddr, exp_haddr(q[0]));
      chk("hsize", 32'(hsize), 32'(exp_hsize(q[0].mask)));
      chk("hwrite", 32'(hwrite), 32'h1);
    end
    if (phase == 2) chk("hwdata", hwdata, q[0].data);
    chk("err", 32'(sb_err), 32'(m_err));
    chk("err_addr", sb_err_addr, m_err_addr);
    chk("fwd_hit", 32'(fwd_hit), 32'(e_hit));
    chk("fwd_mask", 32'(fwd_mask), 32'(e_mask));
    chk("fwd_data", fwd_data, e_data);
  endtask

  // One clock: compare current outputs, advance the model with the inputs
  // that will be sampled at the coming edge, then return at the next negedge.
  task automatic tick();
    bit stored;
    int remain;
    #1;
    if (model_valid) check_outputs();
    if (!rst_n) begin
      q.delete();
      phase = 0; m_err = 1'b0; m_err_addr = '0; model_valid = 1'b1;
    end else begin
      stored = st_req && (q.size() < DEPTH) && (st_mask != 4'b0000);
      case (phase)
        0: if (q.size() > 0) phase = 1;
        1: if (hready) phase = 2;
        default: if (hready) begin
          if (hresp) begin
            if (!m_err) m_err_addr = exp_haddr(q[0]);
            m_err = 1'b1;
          end
          q.delete(0);
          remain = q.size() + int'(stored);
          phase = (remain > 0) ? 1 : 0;
        end
      endcase
      if (stored) q.push_back('{addr: st_addr, mask: st_mask, data: st_data});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    st_req = 1'b1; st_addr = a; st_data = d; st_mask = m;
  endtask

  task automatic single_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                              input logic resp, input logic [31:0] ea, input logic [2:0] es);
    hready = 1'b1; hresp = 1'b0;
    set_store(a, d, m);
    tick();
    st_req = 1'b0;
    chk("sst_htrans_idle", 32'(htrans), 32'h0);
    chk("sst_not_empty", 32'(sb_empty), 32'h0);
    tick();
    chk("sst_htrans_nonseq", 32'(htrans), 32'h2);
    chk("sst_haddr", haddr, ea);
    chk("sst_hsize", 32'(hsize), 32'(es));
    chk("sst_hwrite", 32'(hwrite), 32'h1);
    tick();
    chk("sst_hwdata", hwdata, d);
    chk("sst_htrans_data", 32'(htrans), 32'h0);
    hresp = resp;
    tick();
    hresp = 1'b0;
    chk("sst_empty_after", 32'(sb_empty), 32'h1);
  endtask

  logic [3:0]  mask_tab [12];
  logic [31:0] base_tab [4];

  initial begin
    mask_tab = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h5, 4'h6, 4'hA, 4'h7};
    base_tab = '{32'h100, 32'h104, 32'h200, 32'h0};
    rst_n = 1'b0; st_req = 1'b0; st_addr = '0; st_data = '0; st_mask = '0;
    hready = 1'b1; hresp = 1'b0; ld_addr = '0;

    // Reset values
    tick(); tick();
    chk("rst_htrans", 32'(htrans), 32'h0);
    chk("rst_haddr", haddr, 32'h0);
    chk("rst_hwdata", hwdata, 32'h0);
    chk("rst_hwrite", 32'(hwrite), 32'h0);
    chk("rst_hsize", 32'(hsize), 32'h0);
    chk("rst_err", 32'(sb_err), 32'h0);
    chk("rst_err_addr", sb_err_addr, 32'h0);
    chk("rst_ready", 32'(st_ready), 32'h1);
    chk("rst_empty", 32'(sb_empty), 32'h1);
    rst_n = 1'b1;
    tick();

    // Word, byte and halfword stores
    single_store(32'h0000_1000, 32'hDEAD_BEEF, 4'b1111, 1'b0, 32'h0000_1000, 3'b010);
    single_store(32'h0000_2003, 32'h0C00_0000, 4'b1000, 1'b0, 32'h0000_2003, 3'b000);
    single_store(32'h0000_2002, 32'h0000_BEEF, 4'b1100, 1'b0, 32'h0000_2002, 3'b001);

    // Zero mask is a no-op
    set_store(32'h700, 32'h1234_5678, 4'b0000);
    tick();
    st_req = 1'b0;
    chk("zmask_empty", 32'(sb_empty), 32'h1);
    tick();
    chk("zmask_htrans", 32'(htrans), 32'h0);

    // Fill with bus stalled, refuse a fifth store, then drain
    hready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      set_store(32'h10 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF);
      tick();
    end
    chk("full_ready", 32'(st_ready), 32'h0);
    set_store(32'h80, 32'hBAD0_BAD0, 4'hF);
    tick();
    st_req = 1'b0;
    chk("full_refused_ready", 32'(st_ready), 32'h0);
    hready = 1'b1;
    tick();
    chk("full_ready_before_pop", 32'(st_ready), 32'h0);
    tick();
    chk("full_ready_after_pop", 32'(st_ready), 32'h1);
    chk("full_second_haddr", haddr, 32'h14);
    repeat (8) tick();
    chk("full_drained", 32'(sb_empty), 32'h1);

    // Wait states in both phases
    hready = 1'b0;
    set_store(32'h20, 32'hA5A5_5A5A, 4'hF);
    tick();
    st_req = 1'b0;
    tick();
    repeat (3) begin
      tick();
      chk("ws_haddr_held", haddr, 32'h20);
    end
    hready = 1'b1;
    tick();
    hready = 1'b0;
    repeat (2) begin
      tick();
      chk("ws_hwdata_held", hwdata, 32'hA5A5_5A5A);
    end
    chk("ws_not_empty", 32'(sb_empty), 32'h0);
    hready = 1'b1;
    tick();
    chk("ws_one_pop", 32'(sb_empty), 32'h1);

    // Bus errors: first one sticks, draining continues
    single_store(32'h3000, 32'h1111_2222, 4'hF, 1'b1, 32'h3000, 3'b010);
    chk("err_set", 32'(sb_err), 32'h1);
    chk("err_addr_first", sb_err_addr, 32'h3000);
    single_store(32'h4000, 32'h3333_4444, 4'hF, 1'b1, 32'h4000, 3'b010);
    chk("err_addr_kept", sb_err_addr, 32'h3000);
    single_store(32'h5000, 32'h5555_6666, 4'h3, 1'b0, 32'h5000, 3'b001);

    // Reset during a data phase with three entries queued
    hready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_store(32'h600 + 32'(4 * i), 32'hC000_0000 + 32'(i), 4'hF);
      tick();
    end
    st_req = 1'b0;
    hready = 1'b1;
    tick();
    hready = 1'b0;
    chk("mid_rst_not_empty", 32'(sb_empty), 32'h0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_htrans", 32'(htrans), 32'h0);
    chk("mid_rst_empty", 32'(sb_empty), 32'h1);
    chk("mid_rst_err", 32'(sb_err), 32'h0);
    hready = 1'b1;
    repeat (4) begin
      tick();
      chk("mid_rst_no_xfer", 32'(htrans), 32'h0);
    end

    // Forwarding: youngest of two matching stores
    hready = 1'b0;
    set_store(32'h100, 32'h1111_1111, 4'hF);
    tick();
    set_store(32'h100, 32'h2222_2222, 4'hF);
    tick();
    st_req = 1'b0;
    ld_addr = 32'h100;
    #1;
`ifdef MSRV32_STORE_FWD_EN
    chk("fwd_hit_lit", 32'(fwd_hit), 32'h1);
    chk("fwd_data_lit", fwd_data, 32'h2222_2222);
`else
    chk("fwd_hit_tied", 32'(fwd_hit), 32'h0);
    chk("fwd_data_tied", fwd_data, 32'h0);
`endif
    hready = 1'b1;
    repeat (6) tick();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      st_req  = ($urandom_range(0, 99) < 55);
      st_addr = (base_tab[$urandom_range(0, 3)] | 32'($urandom_range(0, 3)));
      if (st_addr[31:2] == 30'h0) st_addr = $urandom;
      st_mask = mask_tab[$urandom_range(0, 11)];
      st_data = $urandom;
      hready  = ($urandom_range(0, 99) < 70);
      hresp   = ($urandom_range(0, 99) < 12);
      ld_addr = base_tab[$urandom_range(0, 3)];
      rst_n   = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_n = 1'b1; st_req = 1'b0; hready = 1'b1; hresp = 1'b0;
    repeat (20) tick();
    chk("final_empty", 32'(sb_empty), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/msrv32_store_buffer.md
Name: msrv32_store_buffer

Overview:
- Posted-write buffer directly downstream of the store unit.
- Accepts the store unit's aligned data, address, byte mask and write request into a DEPTH-entry FIFO.
- Drains entries onto the AHB-Lite data bus as single NONSEQ write transfers, absorbing HREADY wait states so the core need not stall on slow memory.
- Reports bus errors through a sticky flag.

Parameters:
- DEPTH, 4, number of buffered stores; power of 2, minimum 2.
- PTR_W, $clog2(DEPTH), FIFO pointer width; derived, not overridden.

Ports:
- ms_riscv32_mp_clk_in  in  1  system clock
- ms_riscv32_mp_rst_in  in  1  synchronous, active-low reset
- st_dmdata_in  in  32  lane-aligned store data from the store unit
- st_dmaddr_in  in  32  store address; bits [1:0] ignored
- st_dmwr_mask_in  in  4  byte-lane mask
- st_dmwr_req_in  in  1  store request
- st_ready_out  out  1  buffer can accept; equals !full
- ahb_haddr_out  out  32  bus address
- ahb_htrans_out  out  2  IDLE 2'b00 / NONSEQ 2'b10
- ahb_hwrite_out  out  1  write indicator
- ahb_hsize_out  out  3  transfer size
- ahb_hwdata_out  out  32  write data (data phase)
- ahb_hready_in  in  1  transfer complete / wait
- ahb_hresp_in  in  1  1 = ERROR
- sb_empty_out  out  1  FIFO empty and bus idle (fence/drain indicator)
- sb_err_out  out  1  sticky bus error
- sb_err_addr_out  out  32  address of the first errored transfer
- ld_addr_in  in  32  load address (forwarding)
- ld_fwd_hit_out  out  1  forwarding hit
- ld_fwd_data_out  out  32  forwarded data
- ld_fwd_mask_out  out  4  forwarded byte lanes

Behaviour:
- Reset:
  - Count, pointers and FSM cleared; state IDLE.
  - htrans 2'b00; haddr, hwdata and err_addr 0; hwrite 0; hsize 0; err 0.
  - st_ready_out 1 and sb_empty_out 1 after reset.
  - Reset asserted mid-transfer discards all entries; htrans is IDLE from the next edge.
- Enqueue:
  - Occurs when st_dmwr_req_in && st_ready_out at a clock edge.
  - mask 4'b0000 is accepted but not stored (no-op).
  - Entry holds {addr[31:2], mask, data}.
- Size and address derivation at issue:
  - mask 1111 -> hsize 3'b010, haddr[1:0] = 00.
  - mask 0011 / 1100 -> hsize 3'b001, haddr[1:0] = 00 / 10.
  - single-bit mask -> hsize 3'b000, haddr[1:0] = index of the set bit.
  - Any other mask is treated as word.
- FSM (outputs registered):
  - IDLE: htrans IDLE. If count > 0, load head entry into the address registers -> ADDR.
  - ADDR: htrans NONSEQ, hwrite 1, haddr/hsize stable. If hready_in=1: latch hwdata, htrans IDLE -> DATA. Else hold.
  - DATA: hwdata held. Complete when hready_in=1: pop head. If hresp_in=1 at completion: set sb_err_out; capture sb_err_addr_out only if err was 0. Then -> ADDR with the next entry if count after pop > 0, else IDLE.
- Throughput: one store per 2 cycles with zero wait states.
- Latency: enqueue at edge N -> NONSEQ visible after edge N+1 when the buffer is idle.
- Full/empty:
  - st_ready_out derives from registered count; a pop in the same cycle does not admit a store when full.
  - Enqueue and pop in the same cycle when not full leave count unchanged.
  - Pointers wrap modulo DEPTH.
- sb_empty_out = (count==0) && state==IDLE.
- sb_err_out clears only on reset.

Optional Feature:
MSRV32_STORE_FWD_EN
- With macro:
  - Combinational search of all valid entries plus any in-flight entry for word address == ld_addr_in[31:2].
  - Youngest match wins: hit=1, data and mask from that entry.
  - An entry popped in the current cycle still counts.
- Without macro: ports remain; ld_fwd_hit_out, ld_fwd_data_out and ld_fwd_mask_out are tied 0.

Decomposition:
- Package msrv32_pkg holds:
  - HTRANS_IDLE and HTRANS_NONSEQ.
  - HSIZE_BYTE, HSIZE_HALF and HSIZE_WORD.
  - The state encoding (SB_IDLE, SB_ADDR, SB_DATA).
  - The entry struct width.
- One sub-module, msrv32_sb_fifo: storage, pointers and count, plus the forwarding search port.
- The AHB FSM and size/address derivation stay in the top module.

Test Plan:
- Single word store: addr 0x00001000, data 0xDEADBEEF, mask 1111, hready=1 -> NONSEQ haddr 0x00001000, hsize 010; next cycle hwdata 0xDEADBEEF; sb_empty_out=1 two cycles after issue.
- Byte store: addr 0x00002003, data 0x0C000000, mask 1000 -> haddr 0x00002003, hsize 000. Halfword store: addr 0x00002002, data 0x0000BEEF, mask 1100 -> haddr 0x00002002, hsize 001.
- Fill DEPTH=4 with hready=0 -> st_ready_out=0 after the 4th store and a 5th request is refused. Release hready -> 4 transfers complete in FIFO order; ready returns after the first pop.
- Wait states: hready low 3 cycles in ADDR and 2 in DATA -> haddr and hwdata held stable; exactly one pop.
- Error: hresp=1 with hready=1 on the transfer to 0x00003000 -> sb_err_out=1, sb_err_addr_out=0x00003000; a later error does not overwrite; the buffer keeps draining.
- Reset low during DATA with 3 entries queued -> next cycle htrans=00, sb_empty_out=1, no further transfers. With MSRV32_STORE_FWD_EN: two stores to 0x100 (0x11111111 then 0x22222222), load 0x100 -> hit=1, data 0x22222222.
